// File: rtl/uart_sha_ctrl.sv
// uart_sha_ctrl: pops a message from the UART RX FIFO up to a terminator byte,
// builds the single padded SHA-256 block, streams it to the core as 16
// big-endian words, then latches and holds the digest until acknowledged.
module uart_sha_ctrl #(
  parameter int         MAX_BYTES = 55,
  parameter logic [7:0] TERM_BYTE = 8'h0D
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         rx_empty_i,
  input  logic [7:0]   rx_data_i,
  output logic         rd_uart_o,
  output logic [31:0]  sha_word_o,
  output logic         sha_valid_o,
  input  logic         sha_ready_i,
  input  logic         sha_done_i,
  input  logic [255:0] sha_hash_i,
  output logic [255:0] digest_o,
  output logic         digest_valid_o,
  input  logic         digest_ack_i,
  output logic         busy_o,
  output logic         overflow_o,
  output logic [5:0]   len_o
);

  localparam logic [5:0] MAX_L = 6'(MAX_BYTES);

  typedef enum logic [2:0] {S_COLLECT, S_PAD, S_SEND, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          buf_q [MAX_BYTES];
  logic [5:0]          len_q;
  logic                ovf_q;
  logic [15:0][31:0]   blk_q, blk_d;
  logic [3:0]          idx_q;
  logic [255:0]        digest_q;
  logic                dv_q;

  logic                is_term, hs;
  logic [7:0]          pad_b [64];
  logic [8:0]          bitlen;

  assign is_term = (rx_data_i == TERM_BYTE);
  assign hs      = sha_valid_o & sha_ready_i;
  assign bitlen  = {len_q, 3'b000};

  // State register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_COLLECT;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (rd_uart_o && is_term)      state_d = S_PAD;
      S_PAD:                                    state_d = S_SEND;
      S_SEND:    if (hs && idx_q == 4'd15)      state_d = S_WAIT;
      S_WAIT:    if (sha_done_i)                state_d = S_DONE;
      S_DONE:    if (digest_ack_i)              state_d = S_COLLECT;
      default:                                  state_d = S_COLLECT;
    endcase
  end

  // Outputs: pop only while collecting; word is a mux of registered block state
  always_comb begin
    rd_uart_o      = (state_q == S_COLLECT) && !rx_empty_i;
    sha_valid_o    = (state_q == S_SEND);
    busy_o         = (state_q != S_COLLECT);
    sha_word_o     = blk_q[idx_q];
    digest_o       = digest_q;
    digest_valid_o = dv_q;
    overflow_o     = ovf_q;
    len_o          = len_q;
  end

  // Padded block image: message, 0x80 marker, zero fill, 64-bit bit length
  always_comb begin
    for (int b = 0; b < 64; b++) pad_b[b] = 8'h00;
    for (int b = 0; b < MAX_BYTES; b++)
      if (b < int'(len_q)) pad_b[b] = buf_q[b];
    pad_b[len_q] = 8'h80;
    pad_b[62]    = {7'b0, bitlen[8]};
    pad_b[63]    = bitlen[7:0];
    for (int w = 0; w < 16; w++)
      blk_d[w] = {pad_b[4*w], pad_b[4*w+1], pad_b[4*w+2], pad_b[4*w+3]};
  end

  // Datapath: byte capture, block register, word index, digest latch
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= 8'h00;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      blk_q    <= '0;
      idx_q    <= '0;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: if (rd_uart_o && !is_term) begin
          if (len_q < MAX_L) begin
            buf_q[len_q] <= rx_data_i;
            len_q        <= len_q + 6'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        S_PAD: begin
          blk_q <= blk_d;
          idx_q <= '0;
        end
        S_SEND: if (hs) idx_q <= idx_q + 4'd1;
        S_WAIT: if (sha_done_i) begin
          digest_q <= sha_hash_i;
          dv_q     <= 1'b1;
        end
        S_DONE: if (digest_ack_i) begin
          dv_q  <= 1'b0;
          len_q <= '0;
          ovf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
